uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_pkg.sv | 23 ++
 rtl/frame_buf.sv | 22 ++
 rtl/uart_frame_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_frame_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types for the UART frame receiver.
// FSM encoding, default start-of-frame byte and checksum helper.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam logic [7:0] SOF_DEF = 8'hA5;

  // Checksum arithmetic is a plain mod-256 byte sum.
  function automatic logic [7:0] csum_add(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Payload store for the frame receiver.
// Synchronous write, asynchronous read register file.
module frame_buf #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser on a UART rx FIFO: SOF, length, payload, checksum.
// Holds a good frame until the consumer acknowledges it.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter int         LEN_BIT = 4,
  parameter logic [7:0] SOF     = SOF_DEF,
  parameter int         TIMEOUT = 50000,
  parameter int         TO_BIT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_empty,
  input  logic [7:0]         r_data,
  output logic               rd_uart,
  output logic               frm_valid,
  output logic [7:0]         frm_len,
  input  logic               frm_ack,
  input  logic [LEN_BIT-1:0] buf_addr,
  output logic [7:0]         buf_data,
  output logic               crc_err_tick,
  output logic               len_err_tick,
  output logic               timeout_tick
);

  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_BIT-1:0] TO_LAST   = TO_BIT'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [TO_BIT-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [7:0]        flen_q, flen_d;
  logic              crc_q, crc_d;
  logic              lerr_q, lerr_d;
  logic              to_q, to_d;
  logic              take;
  logic              busy;
  logic              buf_we;
  logic [7:0]        csum_sum;

  // Reset gates the pop so no byte is lost while held in reset.
  assign rd_uart  = ~reset & ~rx_empty & (state_q != HOLD);
  assign take     = rd_uart;
  assign busy     = (state_q == LEN) | (state_q == DATA) |
                    (state_q == CSUM);
  assign csum_sum = csum_add(csum_q, r_data);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    cnt_d   = '0;
    valid_d = valid_q;
    flen_d  = flen_q;
    crc_d   = 1'b0;
    lerr_d  = 1'b0;
    to_d    = 1'b0;
    buf_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take && r_data == SOF) state_d = LEN;
      end
      LEN: begin
        if (take) begin
          if (r_data == 8'd0 || r_data > MAX_LEN_B) begin
            lerr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            len_d   = r_data;
            csum_d  = r_data;
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (take) begin
          buf_we = 1'b1;
          csum_d = csum_sum;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = CSUM;
        end
      end
      CSUM: begin
        if (take) begin
          if (csum_sum == 8'd0) begin
            state_d = HOLD;
            valid_d = 1'b1;
            flen_d  = len_q;
          end else begin
            crc_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (frm_ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A consumed byte always wins over an expiring timeout.
    if (busy && !take) begin
      if (cnt_q == TO_LAST) begin
        to_d    = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + TO_BIT'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      flen_q  <= '0;
      crc_q   <= 1'b0;
      lerr_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      flen_q  <= flen_d;
      crc_q   <= crc_d;
      lerr_q  <= lerr_d;
      to_q    <= to_d;
    end
  end

  assign frm_valid    = valid_q;
  assign frm_len      = flen_q;
  assign crc_err_tick = crc_q;
  assign len_err_tick = lerr_q;
  assign timeout_tick = to_q;

  frame_buf #(
    .AW(LEN_BIT)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(idx_q[LEN_BIT-1:0]),
    .wdata(r_data),
    .raddr(buf_addr),
    .rdata(buf_data)
  );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx with a modelled FWFT rx FIFO.
// Stimulus queues expected events; a monitor checks DUT outputs.
module tb_uart_frame_rx;

  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       frm_valid;
  logic [7:0] frm_len;
  logic       frm_ack = 1'b0;
  logic [3:0] buf_addr = 4'd0;
  logic [7:0] buf_data;
  logic       crc_err_tick;
  logic       len_err_tick;
  logic       timeout_tick;

  always #10 clk = ~clk;

  uart_frame_rx #(
    .MAX_LEN(16),
    .LEN_BIT(4),
    .SOF    (8'hA5),
    .TIMEOUT(TO),
    .TO_BIT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .r_data      (r_data),
    .rd_uart     (rd_uart),
    .frm_valid   (frm_valid),
    .frm_len     (frm_len),
    .frm_ack     (frm_ack),
    .buf_addr    (buf_addr),
    .buf_data    (buf_data),
    .crc_err_tick(crc_err_tick),
    .len_err_tick(len_err_tick),
    .timeout_tick(timeout_tick)
  );

  typedef enum int {EV_FRAME, EV_CRC, EV_LEN, EV_TO} ev_e;
  typedef struct {
    ev_e             kind;
    int              len;
    logic [2:0][7:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fifo[$];
  int         tests = 0;
  int         fails = 0;
  int         hold_cycles = 1;
  logic       rd_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_ev(input ev_e k);
    exp_t e;
    e.kind = k;
    e.len  = 0;
    e.d    = '0;
    sb.push_back(e);
  endtask

  task automatic exp_frame(input int n, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c);
    exp_t e;
    e.kind = EV_FRAME;
    e.len  = n;
    e.d    = {c, b, a};
    sb.push_back(e);
  endtask

  // Bytes are taken MSB first from v.
  task automatic send(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) fifo.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(fifo.size() == 0 && sb.size() == 0 && !frm_valid)
           && n < 600) begin
      @(negedge clk);
      #4;
      n++;
    end
    tests++;
    if (n >= 600) begin
      fails++;
      $display("FAIL %s: %0d events pending, expected 0", name,
               sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // FWFT FIFO model: pop what the DUT took at the previous edge.
  always @(negedge clk) begin
    if (rd_q && fifo.size() > 0) void'(fifo.pop_front());
    rx_empty = (fifo.size() == 0);
    r_data   = rx_empty ? 8'h00 : fifo[0];
    #1;
    rd_q = rd_uart;
  end

  logic prev_v;
  exp_t me;
  ev_e  mk;

  initial begin : monitor
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (crc_err_tick || len_err_tick || timeout_tick) begin
        mk = crc_err_tick ? EV_CRC : len_err_tick ? EV_LEN : EV_TO;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got %s expected none",
                   mk.name());
        end else begin
          me = sb.pop_front();
          chk("event_kind", 32'(mk), 32'(me.kind));
        end
      end
      if (frm_valid && !prev_v) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got len %0d expected none",
                   frm_len);
        end else begin
          me = sb.pop_front();
          chk("frame_kind", 32'(EV_FRAME), 32'(me.kind));
          chk("frm_len", 32'(frm_len), 32'(me.len));
          for (int i = 0; i < me.len && i < 3; i++) begin
            buf_addr = 4'(i);
            #1;
            chk("buf_byte", 32'(buf_data), 32'(me.d[i]));
          end
        end
        repeat (hold_cycles) begin
          @(negedge clk);
          #2;
          chk("hold_rd_uart", 32'(rd_uart), 32'd0);
          chk("hold_valid", 32'(frm_valid), 32'd1);
        end
        frm_ack = 1'b1;
        @(negedge clk);
        #2;
        frm_ack = 1'b0;
        chk("valid_after_ack", 32'(frm_valid), 32'd0);
      end
      prev_v = frm_valid;
    end
  end

  initial begin : stim
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(frm_valid), 32'd0);
    chk("rst_len", 32'(frm_len), 32'd0);
    chk("rst_ticks", 32'({crc_err_tick, len_err_tick, timeout_tick}),
        32'd0);
    chk("rst_rd_uart", 32'(rd_uart), 32'd0);
    #2;
    reset = 1'b0;

    exp_frame(3, 8'h11, 8'h22, 8'h33);
    send(6, 64'hA5_03_11_22_33_97);
    wait_idle("good_frame");

    exp_ev(EV_CRC);
    send(6, 64'hA5_03_11_22_33_98);
    wait_idle("bad_csum");
    chk("crc_no_valid", 32'(frm_valid), 32'd0);

    exp_ev(EV_LEN);
    exp_ev(EV_LEN);
    exp_frame(1, 8'h5A, 8'h00, 8'h00);
    send(2, 64'hA5_11);
    send(2, 64'hA5_00);
    send(4, 64'hA5_01_5A_A5);
    wait_idle("len_err");

    exp_frame(2, 8'hAA, 8'h55, 8'h00);
    send(7, 64'h00_FF_A5_02_AA_55_FF);
    wait_idle("hunting");

    exp_ev(EV_TO);
    send(3, 64'hA5_02_AA);
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!rx_empty && n < 50);
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!timeout_tick && n < TO + 50);
    chk("timeout_latency", 32'(n), 32'(TO));
    wait_idle("timeout");
    exp_frame(3, 8'h11, 8'h22, 8'h33);
    send(6, 64'hA5_03_11_22_33_97);
    wait_idle("after_timeout");

    hold_cycles = 5;
    exp_frame(1, 8'h5A, 8'h00, 8'h00);
    exp_frame(2, 8'hAA, 8'h55, 8'h00);
    send(4, 64'hA5_01_5A_A5);
    send(5, 64'hA5_02_AA_55_FF);
    wait_idle("backpressure");
    hold_cycles = 1;

    send(6, 64'hA5_04_11_22_33_44);
    repeat (3) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(frm_valid), 32'd0);
    chk("mid_rst_len", 32'(frm_len), 32'd0);
    chk("mid_rst_ticks",
        32'({crc_err_tick, len_err_tick, timeout_tick}), 32'd0);
    chk("mid_rst_rd_uart", 32'(rd_uart), 32'd0);
    fifo.delete();
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b0;
    exp_frame(3, 8'h11, 8'h22, 8'h33);
    send(6, 64'hA5_03_11_22_33_97);
    wait_idle("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
